// File: rtl/pyc_mem_arb2_if.sv
// Memory request/response channel shared by the requesters and the downstream port.
// Master drives the request and accepts the response; slave does the opposite.
interface pyc_mem_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_wstrb;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/pyc_mem_arb2.sv
// Two-requester memory arbiter: alternating grant with hold-while-pending, and an
// in-order ID FIFO that routes each downstream response back to its requester.
module pyc_mem_arb2 #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    pyc_mem_arb2_if.slave   m0_if,
    pyc_mem_arb2_if.slave   m1_if,
    pyc_mem_arb2_if.master  s_if
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;
    localparam int PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                       last_grant_q, last_grant_d;
    logic                       lock_valid_q, lock_valid_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic sel_any;
    logic sel_id;
    logic sel_req_valid;
    logic has_room;
    logic req_fire;
    logic fifo_empty;
    logic head_id;
    logic head_resp_ready;
    logic resp_fire;

    // A locked requester keeps the grant until its pending request handshakes.
    always_comb begin
        sel_any = 1'b1;
        sel_id  = 1'b0;
        if (lock_valid_q) begin
            sel_id = lock_id_q;
        end else if (m0_if.req_valid && m1_if.req_valid) begin
            sel_id = ~last_grant_q;
        end else if (m0_if.req_valid) begin
            sel_id = 1'b0;
        end else if (m1_if.req_valid) begin
            sel_id = 1'b1;
        end else begin
            sel_any = 1'b0;
        end
    end

    assign sel_req_valid = sel_id ? m1_if.req_valid : m0_if.req_valid;
    assign has_room      = (count_q < MAX_CNT);

    assign s_if.req_valid = !rst && sel_any && sel_req_valid && has_room;
    assign s_if.req_addr  = sel_id ? m1_if.req_addr  : m0_if.req_addr;
    assign s_if.req_write = sel_id ? m1_if.req_write : m0_if.req_write;
    assign s_if.req_wdata = sel_id ? m1_if.req_wdata : m0_if.req_wdata;
    assign s_if.req_wstrb = sel_id ? m1_if.req_wstrb : m0_if.req_wstrb;

    assign m0_if.req_ready = !rst && sel_any && !sel_id && has_room && s_if.req_ready;
    assign m1_if.req_ready = !rst && sel_any &&  sel_id && has_room && s_if.req_ready;

    assign req_fire = s_if.req_valid && s_if.req_ready;

    // Responses go to the FIFO head; with nothing outstanding they are stalled.
    assign fifo_empty      = (count_q == '0);
    assign head_id         = id_fifo_q[rd_ptr_q];
    assign head_resp_ready = head_id ? m1_if.resp_ready : m0_if.resp_ready;

    assign s_if.resp_ready  = !rst && !fifo_empty && head_resp_ready;
    assign m0_if.resp_valid = !rst && !fifo_empty && !head_id && s_if.resp_valid;
    assign m1_if.resp_valid = !rst && !fifo_empty &&  head_id && s_if.resp_valid;
    assign m0_if.resp_rdata = s_if.resp_rdata;
    assign m1_if.resp_rdata = s_if.resp_rdata;

    assign resp_fire = s_if.resp_valid && s_if.resp_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (req_fire) begin
            lock_valid_d = 1'b0;
            last_grant_d = sel_id;
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        end else if (s_if.req_valid) begin
            lock_valid_d = 1'b1;
            lock_id_d    = sel_id;
        end

        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({req_fire, resp_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // ID storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            id_fifo_q[wr_ptr_q] <= sel_id;
        end
    end
endmodule

// File: tb/tb_pyc_mem_arb2.sv
// Bench for pyc_mem_arb2: directed scenarios plus randomized traffic checked
// against a queue-based model of grant order and response routing.
module tb_pyc_mem_arb2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = (DW + 7) / 8;
    localparam int MAX = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    pyc_mem_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
    pyc_mem_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();
    pyc_mem_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s  ();

    pyc_mem_arb2 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst(rst), .m0_if(m0), .m1_if(m1), .s_if(s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: owners of outstanding requests in issue order,
    // last winner, and a requester whose presented request is still pending.
    int oq[$];
    int lw;
    int pend;

    task automatic idle_inputs();
        m0.req_valid = 0; m0.req_addr = '0; m0.req_write = 0; m0.req_wdata = '0;
        m0.req_wstrb = '0; m0.resp_ready = 0;
        m1.req_valid = 0; m1.req_addr = '0; m1.req_write = 0; m1.req_wdata = '0;
        m1.req_wstrb = '0; m1.resp_ready = 0;
        s.req_ready = 0; s.resp_valid = 0; s.resp_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        oq.delete();
        lw   = 1;
        pend = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m0.req_valid = 1; m1.req_valid = 1; s.req_ready = 1;
        s.resp_valid = 1; m0.resp_ready = 1; m1.resp_ready = 1;
        #2;
        vectors++;
        if (s.req_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_s_req_valid: got %b want 0", s.req_valid); end
        vectors++;
        if (m0.req_ready !== 1'b0 || m1.req_ready !== 1'b0) begin miscompares++;
            $display("FAIL reset_req_ready: got m0=%b m1=%b want 0 0", m0.req_ready, m1.req_ready); end
        vectors++;
        if (m0.resp_valid !== 1'b0 || m1.resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_resp_valid: got m0=%b m1=%b want 0 0", m0.resp_valid, m1.resp_valid); end
        vectors++;
        if (s.resp_ready !== 1'b0) begin miscompares++;
            $display("FAIL reset_s_resp_ready: got %b want 0", s.resp_ready); end
        do_reset();
    endtask

    task automatic test_alternate();
        logic e0, r0, r1;
        do_reset();
        m0.req_addr = 32'h1000; m1.req_addr = 32'h2000;
        m0.req_valid = 1; m1.req_valid = 1; s.req_ready = 1;
        s.resp_valid = 1; m0.resp_ready = 1; m1.resp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            s.resp_rdata = 32'(i);
            @(negedge clk);
            e0 = (i % 2 == 0);
            r0 = (i > 0) && ((i - 1) % 2 == 0);
            r1 = (i > 0) && ((i - 1) % 2 == 1);
            vectors++;
            if (m0.req_ready !== e0 || m1.req_ready !== !e0) begin miscompares++;
                $display("FAIL alt_grant c%0d: got m0=%b m1=%b want m0=%b m1=%b", i,
                         m0.req_ready, m1.req_ready, e0, !e0); end
            vectors++;
            if (s.req_valid !== 1'b1 || s.req_addr !== (e0 ? 32'h1000 : 32'h2000)) begin miscompares++;
                $display("FAIL alt_addr c%0d: got v=%b a=%h want v=1 a=%h", i, s.req_valid,
                         s.req_addr, e0 ? 32'h1000 : 32'h2000); end
            vectors++;
            if (m0.resp_valid !== r0 || m1.resp_valid !== r1) begin miscompares++;
                $display("FAIL alt_route c%0d: got m0=%b m1=%b want m0=%b m1=%b", i,
                         m0.resp_valid, m1.resp_valid, r0, r1); end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        m1.req_valid = 1; m1.req_addr = 32'hB0B0; m1.req_write = 1; m1.req_wdata = 32'hBEEF;
        m0.req_addr = 32'hA0A0; m0.req_write = 0; m0.req_wdata = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) m0.req_valid = 1;
            @(negedge clk);
            vectors++;
            if (s.req_valid !== 1'b1 || s.req_addr !== 32'hB0B0 || s.req_write !== 1'b1 ||
                m1.req_ready !== 1'b0 || m0.req_ready !== 1'b0) begin miscompares++;
                $display("FAIL lock_hold c%0d: got v=%b a=%h w=%b r0=%b r1=%b want v=1 a=b0b0 w=1 r0=0 r1=0",
                         i, s.req_valid, s.req_addr, s.req_write, m0.req_ready, m1.req_ready); end
            tick();
        end
        s.req_ready = 1;
        @(negedge clk);
        vectors++;
        if (m1.req_ready !== 1'b1 || m0.req_ready !== 1'b0 || s.req_wdata !== 32'hBEEF) begin miscompares++;
            $display("FAIL lock_release: got r0=%b r1=%b d=%h want r0=0 r1=1 d=beef",
                     m0.req_ready, m1.req_ready, s.req_wdata); end
        tick();
        m1.req_valid = 0;
        @(negedge clk);
        vectors++;
        if (m0.req_ready !== 1'b1 || s.req_addr !== 32'hA0A0 || s.req_write !== 1'b0) begin miscompares++;
            $display("FAIL lock_next: got r0=%b a=%h w=%b want r0=1 a=a0a0 w=0",
                     m0.req_ready, s.req_addr, s.req_write); end
        tick();
    endtask

    task automatic test_order();
        logic [31:0] rd [3];
        logic        to_m1 [3];
        rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
        to_m1[0] = 0; to_m1[1] = 1; to_m1[2] = 0;
        do_reset();
        s.req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            m0.req_valid = !to_m1[i]; m1.req_valid = to_m1[i];
            @(negedge clk);
            vectors++;
            if ((to_m1[i] ? m1.req_ready : m0.req_ready) !== 1'b1) begin miscompares++;
                $display("FAIL order_issue %0d: got ready=0 want 1", i); end
            tick();
        end
        m0.req_valid = 0; m1.req_valid = 0;
        m0.resp_ready = 1; m1.resp_ready = 1; s.resp_valid = 1;
        for (int i = 0; i < 3; i++) begin
            s.resp_rdata = rd[i];
            @(negedge clk);
            vectors++;
            if (m0.resp_valid !== !to_m1[i] || m1.resp_valid !== to_m1[i] || s.resp_ready !== 1'b1 ||
                m0.resp_rdata !== rd[i] || m1.resp_rdata !== rd[i]) begin miscompares++;
                $display("FAIL order_resp %0d: got v0=%b v1=%b rr=%b d0=%h d1=%h want v0=%b v1=%b rr=1 d=%h",
                         i, m0.resp_valid, m1.resp_valid, s.resp_ready, m0.resp_rdata,
                         m1.resp_rdata, !to_m1[i], to_m1[i], rd[i]); end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (s.resp_ready !== 1'b0 || m0.resp_valid !== 1'b0 || m1.resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL order_spurious: got rr=%b v0=%b v1=%b want 0 0 0",
                     s.resp_ready, m0.resp_valid, m1.resp_valid); end
        tick();
    endtask

    task automatic test_full();
        logic e;
        do_reset();
        m0.req_valid = 1; s.req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = (i < MAX);
            vectors++;
            if (m0.req_ready !== e || s.req_valid !== e) begin miscompares++;
                $display("FAIL full_accept c%0d: got r=%b v=%b want %b", i, m0.req_ready, s.req_valid, e); end
            tick();
        end
        s.resp_valid = 1; m0.resp_ready = 1;
        @(negedge clk);
        vectors++;
        if (s.req_valid !== 1'b0 || s.resp_ready !== 1'b1 || m0.resp_valid !== 1'b1) begin miscompares++;
            $display("FAIL full_no_bypass: got v=%b rr=%b rv=%b want 0 1 1",
                     s.req_valid, s.resp_ready, m0.resp_valid); end
        tick();
        s.resp_valid = 0;
        @(negedge clk);
        vectors++;
        if (s.req_valid !== 1'b1 || m0.req_ready !== 1'b1) begin miscompares++;
            $display("FAIL full_resume: got v=%b r=%b want 1 1", s.req_valid, m0.req_ready); end
        tick();
    endtask

    task automatic test_head_stall();
        do_reset();
        s.req_ready = 1;
        m1.req_valid = 1;
        tick();
        m1.req_valid = 0; m0.req_valid = 1;
        tick();
        m0.req_valid = 0;
        s.resp_valid = 1; s.resp_rdata = 32'h55; m1.resp_ready = 0; m0.resp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (m1.resp_valid !== 1'b1 || m0.resp_valid !== 1'b0 || s.resp_ready !== 1'b0) begin miscompares++;
                $display("FAIL head_stall c%0d: got v1=%b v0=%b rr=%b want 1 0 0",
                         i, m1.resp_valid, m0.resp_valid, s.resp_ready); end
            tick();
        end
        m1.resp_ready = 1;
        @(negedge clk);
        vectors++;
        if (s.resp_ready !== 1'b1 || m1.resp_valid !== 1'b1) begin miscompares++;
            $display("FAIL head_accept: got rr=%b v1=%b want 1 1", s.resp_ready, m1.resp_valid); end
        tick();
        @(negedge clk);
        vectors++;
        if (m0.resp_valid !== 1'b1 || m1.resp_valid !== 1'b0 || s.resp_ready !== 1'b1) begin miscompares++;
            $display("FAIL head_next: got v0=%b v1=%b rr=%b want 1 0 1",
                     m0.resp_valid, m1.resp_valid, s.resp_ready); end
        tick();
    endtask

    task automatic test_reset_outstanding();
        logic e;
        do_reset();
        m0.req_valid = 1; s.req_ready = 1;
        tick();
        tick();
        s.resp_valid = 1; m0.resp_ready = 1; m1.resp_ready = 1;
        rst = 1'b1;
        #1;
        vectors++;
        if (s.req_valid !== 1'b0 || m0.req_ready !== 1'b0 || m0.resp_valid !== 1'b0 ||
            m1.resp_valid !== 1'b0 || s.resp_ready !== 1'b0) begin miscompares++;
            $display("FAIL rst_async: got v=%b r0=%b rv0=%b rv1=%b rr=%b want all 0",
                     s.req_valid, m0.req_ready, m0.resp_valid, m1.resp_valid, s.resp_ready); end
        tick();
        rst = 1'b0;
        m0.req_valid = 0;
        @(negedge clk);
        vectors++;
        if (s.resp_ready !== 1'b0 || m0.resp_valid !== 1'b0 || m1.resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_discard: got rr=%b v0=%b v1=%b want 0 0 0",
                     s.resp_ready, m0.resp_valid, m1.resp_valid); end
        tick();
        s.resp_valid = 0; m0.req_valid = 1;
        for (int i = 0; i < MAX + 1; i++) begin
            @(negedge clk);
            e = (i < MAX);
            vectors++;
            if (m0.req_ready !== e) begin miscompares++;
                $display("FAIL rst_count c%0d: got r=%b want %b", i, m0.req_ready, e); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pa [2];
        logic          pw [2];
        logic [DW-1:0] pd [2];
        logic [SW-1:0] ps [2];
        logic          v  [2];
        logic          hold [2];
        logic          rr [2];
        logic          e_rdy [2];
        logic          e_rv [2];
        logic          e_sreq, e_srr, srdy, srv, push, pop;
        int            who;
        do_reset();
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!hold[k]) begin
                    v[k]  = ($urandom_range(0, 4) < 3);
                    pa[k] = $urandom; pw[k] = 1'($urandom); pd[k] = $urandom; ps[k] = SW'($urandom);
                end
                rr[k] = ($urandom_range(0, 3) != 0);
            end
            srdy = ($urandom_range(0, 3) != 0);
            srv  = 1'($urandom);
            m0.req_valid = v[0]; m0.req_addr = pa[0]; m0.req_write = pw[0];
            m0.req_wdata = pd[0]; m0.req_wstrb = ps[0]; m0.resp_ready = rr[0];
            m1.req_valid = v[1]; m1.req_addr = pa[1]; m1.req_write = pw[1];
            m1.req_wdata = pd[1]; m1.req_wstrb = ps[1]; m1.resp_ready = rr[1];
            s.req_ready = srdy; s.resp_valid = srv; s.resp_rdata = $urandom;
            @(negedge clk);
            if (pend >= 0) who = pend;
            else if (v[0] && v[1]) who = 1 - lw;
            else if (v[0]) who = 0;
            else if (v[1]) who = 1;
            else who = -1;
            e_sreq = (who >= 0) && v[who] && (oq.size() < MAX);
            for (int k = 0; k < 2; k++) begin
                e_rdy[k] = (who == k) && (oq.size() < MAX) && srdy;
                e_rv[k]  = (oq.size() > 0) && (oq[0] == k) && srv;
            end
            e_srr = (oq.size() > 0) && rr[oq[0]];
            vectors++;
            if (s.req_valid !== e_sreq || m0.req_ready !== e_rdy[0] || m1.req_ready !== e_rdy[1]) begin
                miscompares++;
                $display("FAIL rnd_req c%0d: got v=%b r0=%b r1=%b want v=%b r0=%b r1=%b", c,
                         s.req_valid, m0.req_ready, m1.req_ready, e_sreq, e_rdy[0], e_rdy[1]); end
            if (e_sreq) begin
                vectors++;
                if (s.req_addr !== pa[who] || s.req_write !== pw[who] ||
                    s.req_wdata !== pd[who] || s.req_wstrb !== ps[who]) begin miscompares++;
                    $display("FAIL rnd_payload c%0d: got a=%h w=%b d=%h s=%h want a=%h w=%b d=%h s=%h", c,
                             s.req_addr, s.req_write, s.req_wdata, s.req_wstrb,
                             pa[who], pw[who], pd[who], ps[who]); end
            end
            vectors++;
            if (m0.resp_valid !== e_rv[0] || m1.resp_valid !== e_rv[1] || s.resp_ready !== e_srr ||
                m0.resp_rdata !== s.resp_rdata || m1.resp_rdata !== s.resp_rdata) begin miscompares++;
                $display("FAIL rnd_resp c%0d: got v0=%b v1=%b rr=%b want v0=%b v1=%b rr=%b", c,
                         m0.resp_valid, m1.resp_valid, s.resp_ready, e_rv[0], e_rv[1], e_srr); end
            pop  = (oq.size() > 0) && srv && e_srr;
            push = e_sreq && srdy;
            if (pop) void'(oq.pop_front());
            if (push) begin
                oq.push_back(who);
                lw   = who;
                pend = -1;
            end else if (e_sreq) begin
                pend = who;
            end
            for (int k = 0; k < 2; k++) hold[k] = v[k] && !(push && who == k);
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alternate();
        test_lock();
        test_order();
        test_full();
        test_head_stall();
        test_reset_outstanding();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d", vectors);
        $fatal(1);
    end
endmodule
